// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-over-fetch fixed-priority arbiter for one
// shared single-ported memory bus, with bounded-timeout abort.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CLAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    DBUSY,
    IBUSY
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          we_nx;
  logic [31:0]   addr_nx;
  logic [31:0]   wdata_nx;
  logic          to_hit;
  logic          fin;
  logic [31:0]   rsp;

  assign m_req = (state != IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      m_we    <= we_nx;
      m_addr  <= addr_nx;
      m_wdata <= wdata_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    we_nx       = m_we;
    addr_nx     = m_addr;
    wdata_nx    = m_wdata;
    to_hit      = 1'b0;
    fin         = 1'b0;
    i_ack       = 1'b0;
    d_ack       = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    timeout_err = 1'b0;
    rsp         = m_ack ? m_rdata : ERR_RDATA;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (d_req) begin
          state_nx = DBUSY;
          we_nx    = d_we;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
        end else if (i_req) begin
          state_nx = IBUSY;
          we_nx    = 1'b0;
          addr_nx  = i_addr;
        end
      end
      DBUSY, IBUSY: begin
        // a real m_ack always wins over a same-cycle timeout
        to_hit      = TO_EN && (cnt == CLAST) && !m_ack;
        fin         = m_ack || to_hit;
        timeout_err = to_hit;
        if (state == DBUSY) begin
          d_ack   = fin;
          d_rdata = fin ? rsp : '0;
        end else begin
          i_ack   = fin;
          i_rdata = fin ? rsp : '0;
        end
        if (fin) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt != CMAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory bus between the core's instruction-fetch port and data port.
- Fixed priority: data requests are granted before instruction requests.
- Runs a per-transaction request/acknowledge handshake with a bounded timeout.
- Sits between the core and the memory model, turning the core's two independent ports into serialized bus transactions.

Parameters:
- TIMEOUT_CYCLES, 16, max busy cycles before forced abort; 0 disables the timeout.
- ERR_RDATA, 32'h0000_0000, read data returned on an aborted transaction.

Ports:
- clk  input  1  clock
- reset  input  1  reset; one clock, asynchronous, active-high
- i_req  input  1  fetch request; held until i_ack
- i_addr  input  32  fetch address
- i_ack  output  1  fetch done, one-cycle pulse
- i_rdata  output  32  fetch data, valid with i_ack
- d_req  input  1  data request; held until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data address
- d_wdata  input  32  store data
- d_ack  output  1  data done, one-cycle pulse
- d_rdata  output  32  load data, valid with d_ack
- m_req  output  1  memory bus request
- m_we  output  1  memory write enable
- m_addr  output  32  memory address
- m_wdata  output  32  memory write data
- m_ack  input  1  memory done, one-cycle pulse
- m_rdata  input  32  memory read data, valid with m_ack
- busy  output  1  transaction in flight
- timeout_err  output  1  one-cycle pulse on abort

Behaviour:
- Reset values:
  - state = IDLE; m_req = m_we = 0; m_addr = m_wdata = 0; timeout counter = 0.
  - i_ack = d_ack = busy = timeout_err = 0; i_rdata = d_rdata = 0.
  - Reset asserted mid-transaction: m_req drops immediately; no ack is ever issued for that transaction.
- FSM states: IDLE, DBUSY, IBUSY.
- IDLE:
  - d_req → DBUSY; latch d_addr, d_we, d_wdata into the m_* registers.
  - Otherwise i_req → IBUSY; latch i_addr, m_we = 0.
  - Both requests in the same cycle → DBUSY; i_req waits.
- DBUSY / IBUSY:
  - m_req and busy = 1; m_* registers hold stable until the transaction ends.
  - Counter increments each cycle without m_ack.
- Completion: m_ack in DBUSY (IBUSY) → combinational d_ack (i_ack) = 1 and d_rdata (i_rdata) = m_rdata in that same cycle.
  - Registered m_req drops the next cycle; state → IDLE; counter cleared.
- Latency:
  - Request sampled at edge N → m_req high from cycle N+1.
  - Earliest ack in cycle N+1.
  - Next grant no earlier than the edge after the ack; there is always one IDLE cycle between transactions.
- Requester rule: req still high in the cycle after its ack is a new request. Input changes while not yet acked are ignored, because the m_* registers are latched at grant.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter reaches TIMEOUT_CYCLES − 1 with no m_ack → in that cycle the owner's ack pulses with rdata = ERR_RDATA, and timeout_err = 1.
  - State → IDLE.
  - A late m_ack arriving in IDLE is ignored.
  - m_ack and the timeout in the same cycle → normal completion; timeout_err = 0.
- m_ack in IDLE → no effect.
- Write acks still drive d_rdata = m_rdata, which the core ignores.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wrapping.
- No starvation guard. The core never asserts d_req in consecutive transactions without an intervening fetch, so instruction fetch always progresses.

Test Plan:
- i_req with i_addr = 0x0000_0010, memory acks one cycle after m_req with 0x2002_0005 → m_addr = 0x10, m_we = 0; i_ack pulses with i_rdata = 0x2002_0005; busy low the next cycle.
- i_req and d_req (d_we = 1, d_addr = 0x40, d_wdata = 0xCAFE_F00D) in the same cycle → write issued first with m_we = 1, m_wdata = 0xCAFEF00D; after d_ack, one IDLE cycle, then fetch issued; i_ack last.
- d_req read at 0x80, memory waits 5 cycles then acks with 0x1234_5678 → m_addr stable at 0x80 for all 5 cycles; d_ack pulses once with 0x12345678.
- TIMEOUT_CYCLES = 4, memory never acks → d_ack and timeout_err pulse in the 4th busy cycle with d_rdata = 0; a later stray m_ack produces no ack.
- Reset pulsed mid-transaction between clock edges → m_req, busy and all acks go low immediately; after release a new i_req completes normally.
- m_ack coinciding with the timeout cycle → normal completion with m_rdata; timeout_err = 0.
